fp_s2_arbiter: RTL and testbench

FP_S2_ARBITER -- requirements
Module: fp_s2_arbiter

---
 rtl/fp_s2_arbiter.sv | 146 ++++++++++++++
 tb/tb_fp_s2_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_s2_arbiter.sv
// fp_s2_arbiter: round-robin front end sharing one multi-cycle FP unit between two requesters.
// Optional macro FP_ARB_TIMEOUT_EN aborts an operation whose fp_done never arrives.
module fp_s2_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        r0_req,
    input  logic [2:0]  r0_n,
    input  logic [31:0] r0_dataa,
    input  logic [31:0] r0_datab,
    output logic        r0_ack,
    output logic        r0_rsp_valid,
    input  logic        r1_req,
    input  logic [2:0]  r1_n,
    input  logic [31:0] r1_dataa,
    input  logic [31:0] r1_datab,
    output logic        r1_ack,
    output logic        r1_rsp_valid,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        fp_clk_en,
    output logic        fp_start,
    output logic [2:0]  fp_n,
    output logic [31:0] fp_dataa,
    output logic [31:0] fp_datab,
    output logic        fp_reset,
    output logic        fp_reset_req,
    input  logic        fp_done,
    input  logic [31:0] fp_result
);

    // Handshake: rN_req is held until rN_rsp_valid; rN_ack and rN_rsp_valid are
    // single-cycle pulses, and fp_start coincides with the winner's ack.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    logic   last_grant;
    logic   winner;
    logic   pick;

    assign fp_clk_en = 1'b1;

    // On contention the requester not granted last wins; last_grant=1 means r1.
    always_comb begin
        pick = r1_req;
        if (r0_req && r1_req) pick = ~last_grant;
    end

`ifdef FP_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] wait_cnt;
    logic          wait_expired;
    assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign rsp_err      = 1'b0;
    assign fp_reset     = 1'b0;
    assign fp_reset_req = 1'b0;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            winner       <= 1'b0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            fp_start     <= 1'b0;
            fp_n         <= '0;
            fp_dataa     <= '0;
            fp_datab     <= '0;
            rsp_result   <= '0;
`ifdef FP_ARB_TIMEOUT_EN
            rsp_err      <= 1'b0;
            fp_reset     <= 1'b0;
            fp_reset_req <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            fp_start     <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
            rsp_err      <= 1'b0;
            fp_reset     <= 1'b0;
            fp_reset_req <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        winner     <= pick;
                        last_grant <= pick;
                        fp_n       <= pick ? r1_n     : r0_n;
                        fp_dataa   <= pick ? r1_dataa : r0_dataa;
                        fp_datab   <= pick ? r1_datab : r0_datab;
                        fp_start   <= 1'b1;
                        r0_ack     <= ~pick;
                        r1_ack     <= pick;
                        state      <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (fp_done) begin
                        rsp_result   <= fp_result;
                        r0_rsp_valid <= ~winner;
                        r1_rsp_valid <= winner;
                        state        <= RESP;
                    end
`ifdef FP_ARB_TIMEOUT_EN
                    else if (state == ISSUE) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else if (wait_expired) begin
                        // Abandon the hung op: reset the FP unit and report an error result.
                        rsp_result   <= '0;
                        rsp_err      <= 1'b1;
                        fp_reset     <= 1'b1;
                        fp_reset_req <= 1'b1;
                        r0_rsp_valid <= ~winner;
                        r1_rsp_valid <= winner;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`else
                    else begin
                        state <= WAIT;
                    end
`endif
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_s2_arbiter.sv
// tb_fp_s2_arbiter: random two-requester traffic plus directed cases for fp_s2_arbiter.
// Optional macro FP_ARB_TIMEOUT_EN adds the timeout case (TIMEOUT_CYCLES=8).
module tb_fp_s2_arbiter;

    localparam int TOUT = 8;

    logic        clk_clk;
    logic        reset_reset_n;
    logic        req [2];
    logic [2:0]  opn [2];
    logic [31:0] opa [2];
    logic [31:0] opb [2];
    logic        r0_ack, r1_ack, r0_rsp_valid, r1_rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_err, fp_clk_en, fp_start, fp_reset, fp_reset_req;
    logic [2:0]  fp_n;
    logic [31:0] fp_dataa, fp_datab;
    logic        fp_done;
    logic [31:0] fp_result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected response: {err, requester, result} and the cycle it must appear in.
    logic [33:0] exp_q[$];
    int          exp_cyc_q[$];
    int          grant_log[$];
    int          ack_cnt [2];
    int          rsp_cnt [2];

    logic        smp_req [2];
    logic [2:0]  smp_n [2];
    logic [31:0] smp_a [2];
    logic [31:0] smp_b [2];
    logic        model_last;
    logic [31:0] last_result;
    int          fixed_delay;
    logic        fixed_res_en;
    logic [31:0] fixed_res;

    logic [33:0] mon_e;
    int          mon_c;
    logic        mon_err;

    fp_s2_arbiter #(.TIMEOUT_CYCLES(TOUT)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .r0_req(req[0]), .r0_n(opn[0]), .r0_dataa(opa[0]), .r0_datab(opb[0]),
        .r0_ack(r0_ack), .r0_rsp_valid(r0_rsp_valid),
        .r1_req(req[1]), .r1_n(opn[1]), .r1_dataa(opa[1]), .r1_datab(opb[1]),
        .r1_ack(r1_ack), .r1_rsp_valid(r1_rsp_valid),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .fp_clk_en(fp_clk_en), .fp_start(fp_start), .fp_n(fp_n),
        .fp_dataa(fp_dataa), .fp_datab(fp_datab),
        .fp_reset(fp_reset), .fp_reset_req(fp_reset_req),
        .fp_done(fp_done), .fp_result(fp_result)
    );

    // ---------------- clock / reset ----------------
    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // Requester inputs as the DUT samples them at each rising edge.
    always @(posedge clk_clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            smp_req[i] <= req[i];
            smp_n[i]   <= opn[i];
            smp_a[i]   <= opa[i];
            smp_b[i]   <= opb[i];
        end
    end

    task automatic check(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(act === exp, name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(act === exp, name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic check_reset_outs(input string tag);
        chk1({tag, ":r0_ack"}, r0_ack, 1'b0);
        chk1({tag, ":r1_ack"}, r1_ack, 1'b0);
        chk1({tag, ":r0_rsp_valid"}, r0_rsp_valid, 1'b0);
        chk1({tag, ":r1_rsp_valid"}, r1_rsp_valid, 1'b0);
        chk({tag, ":rsp_result"}, rsp_result, 32'h0);
        chk1({tag, ":rsp_err"}, rsp_err, 1'b0);
        chk1({tag, ":fp_clk_en"}, fp_clk_en, 1'b1);
        chk1({tag, ":fp_start"}, fp_start, 1'b0);
        chk({tag, ":fp_n"}, {29'b0, fp_n}, 32'h0);
        chk({tag, ":fp_dataa"}, fp_dataa, 32'h0);
        chk({tag, ":fp_datab"}, fp_datab, 32'h0);
        chk1({tag, ":fp_reset"}, fp_reset, 1'b0);
        chk1({tag, ":fp_reset_req"}, fp_reset_req, 1'b0);
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns the number of rising edges from raising req to seeing rsp_valid.
    task automatic run_op(input int id, input int gap, input logic [2:0] n,
                          input logic [31:0] a, input logic [31:0] b, output int lat);
        int t;
        repeat (gap) begin @(posedge clk_clk); #1; end
        req[id] = 1'b1; opn[id] = n; opa[id] = a; opb[id] = b;
        t = 0;
        do begin @(posedge clk_clk); #1; t++; end
        while (!(id == 0 ? r0_ack : r1_ack) && t < 200);
        check(t < 200, "ack_wait_bound", t, 200);
        // Operands are don't-care after ack; scramble them to expose unlatched paths.
        opn[id] = 3'($urandom); opa[id] = $urandom; opb[id] = $urandom;
        while (!(id == 0 ? r0_rsp_valid : r1_rsp_valid) && t < 400) begin
            @(posedge clk_clk); #1; t++;
        end
        check(t < 400, "rsp_wait_bound", t, 400);
        lat = t;
        req[id] = 1'b0;
    endtask

    task automatic run_rand(input int id, input int gap, output int lat);
        run_op(id, gap, 3'($urandom), $urandom, $urandom, lat);
    endtask

    // ---------------- FP unit + arbitration reference model ----------------
    initial begin : fp_model
        int w, d, lim;
        logic aborted;
        logic [31:0] res, ha, hb;
        logic [2:0] hn;
        fp_done = 1'b0;
        fp_result = '0;
        forever begin
            @(posedge clk_clk); #1;
            fp_done = 1'b0;
            fp_result = $urandom;
            if (reset_reset_n && fp_start) begin
                w = 0;
                if (!smp_req[0] && !smp_req[1]) check(1'b0, "spurious_start", 32'h1, 32'h0);
                else if (smp_req[0] && smp_req[1]) w = model_last ? 0 : 1;
                else w = smp_req[1] ? 1 : 0;
                model_last = w[0];
                grant_log.push_back(w);
                chk1("issue_r0_ack", r0_ack, w == 0);
                chk1("issue_r1_ack", r1_ack, w == 1);
                hn = smp_n[w]; ha = smp_a[w]; hb = smp_b[w];
                chk("issue_fp_n", {29'b0, fp_n}, {29'b0, hn});
                chk("issue_fp_dataa", fp_dataa, ha);
                chk("issue_fp_datab", fp_datab, hb);
                res = fixed_res_en ? fixed_res : $urandom;
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                lim = d;
`ifdef FP_ARB_TIMEOUT_EN
                if (d > TOUT) lim = TOUT;
`endif
                aborted = 1'b0;
                for (int k = 0; k < lim; k++) begin
                    @(posedge clk_clk); #1;
                    fp_result = $urandom;
                    if (!reset_reset_n) begin aborted = 1'b1; break; end
                    chk1("wait_fp_start", fp_start, 1'b0);
                    chk("hold_fp_n", {29'b0, fp_n}, {29'b0, hn});
                    chk("hold_fp_dataa", fp_dataa, ha);
                    chk("hold_fp_datab", fp_datab, hb);
                end
                if (!aborted) begin
                    if (d > lim) begin
                        exp_q.push_back({1'b1, w[0], 32'h0});
                    end else begin
                        fp_done = 1'b1;
                        fp_result = res;
                        exp_q.push_back({1'b0, w[0], res});
                    end
                    exp_cyc_q.push_back(cyc + 1);
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_clk) begin
        if (reset_reset_n) begin
            chk1("fp_clk_en", fp_clk_en, 1'b1);
            chk1("ack_exclusive", r0_ack & r1_ack, 1'b0);
            chk1("rsp_exclusive", r0_rsp_valid & r1_rsp_valid, 1'b0);
            chk1("start_vs_ack", fp_start, r0_ack | r1_ack);
            if (r0_ack) ack_cnt[0]++;
            if (r1_ack) ack_cnt[1]++;
            mon_err = 1'b0;
            if (r0_rsp_valid || r1_rsp_valid) begin
                if (r0_rsp_valid) rsp_cnt[0]++;
                if (r1_rsp_valid) rsp_cnt[1]++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_rsp", {31'b0, r1_rsp_valid}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    chk1("rsp_requester", r1_rsp_valid, mon_e[32]);
                    chk("rsp_result", rsp_result, mon_e[31:0]);
                    chk1("rsp_err", rsp_err, mon_e[33]);
                    chk("rsp_cycle", cyc, mon_c);
                    mon_err = mon_e[33];
                    last_result = mon_e[31:0];
                end
            end else begin
                chk("rsp_result_hold", rsp_result, last_result);
                chk1("rsp_err_idle", rsp_err, 1'b0);
            end
            chk1("fp_reset", fp_reset, mon_err);
            chk1("fp_reset_req", fp_reset_req, mon_err);
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int l0, l1, a1, rs;
        int exp_order [4];
        exp_order = '{0, 1, 0, 1};
        reset_reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; opn[i] = '0; opa[i] = '0; opb[i] = '0;
            ack_cnt[i] = 0; rsp_cnt[i] = 0;
        end
        model_last = 1'b1;
        last_result = '0;
        fixed_delay = -1;
        fixed_res_en = 1'b0;
        fixed_res = '0;
        repeat (3) @(posedge clk_clk);
        #1;
        check_reset_outs("por");
        reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;

        // Contention from reset: r0 first, then alternation.
        fork
            begin run_rand(0, 0, l0); run_rand(0, 0, l0); end
            begin run_rand(1, 0, l1); run_rand(1, 0, l1); end
        join
        chk("grant_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < grant_log.size()) chk("contention_order", grant_log[k], exp_order[k]);

        // Single op, done two cycles after fp_start.
        fixed_delay = 2; fixed_res_en = 1'b1; fixed_res = 32'h40400000;
        run_op(0, 1, 3'd1, 32'h3f800000, 32'h40000000, l0);
        chk("single_latency", l0, 4);
        chk("single_result", rsp_result, 32'h40400000);

        // Done in the ISSUE cycle: minimum latency.
        fixed_delay = 0; fixed_res = 32'hc0a00000;
        run_rand(1, 1, l1);
        chk("min_latency", l1, 2);
        chk("min_result", rsp_result, 32'hc0a00000);
        fixed_res_en = 1'b0;

        // A request pulse while busy is dropped.
        fixed_delay = 3;
        a1 = ack_cnt[1];
        fork
            run_rand(0, 1, l0);
            begin
                repeat (3) @(posedge clk_clk);
                #1; req[1] = 1'b1; opa[1] = $urandom;
                @(posedge clk_clk);
                #1; req[1] = 1'b0;
            end
        join
        repeat (4) @(posedge clk_clk);
        #1;
        chk("dropped_req_acks", ack_cnt[1] - a1, 0);

        // Random traffic from both requesters.
        fixed_delay = -1;
        fork
            for (int k = 0; k < 12; k++) run_rand(0, int'($urandom_range(0, 3)), l0);
            for (int k = 0; k < 12; k++) run_rand(1, int'($urandom_range(0, 3)), l1);
        join

`ifdef FP_ARB_TIMEOUT_EN
        fixed_delay = 30;
        run_rand(1, 1, l1);
        chk("timeout_latency", l1, TOUT + 2);
        chk("timeout_result", rsp_result, 32'h0);
        fixed_delay = -1;
`endif

        // Reset while the op sits in WAIT: abandoned, no response afterwards.
        fixed_delay = 20;
        @(posedge clk_clk); #1;
        req[0] = 1'b1; opn[0] = 3'($urandom); opa[0] = $urandom; opb[0] = $urandom;
        l0 = 0;
        do begin @(posedge clk_clk); #1; l0++; end while (!fp_start && l0 < 20);
        check(l0 < 20, "midop_start_bound", l0, 20);
        @(posedge clk_clk);
        #3;
        reset_reset_n = 1'b0;
        #1;
        check_reset_outs("midop");
        rs = rsp_cnt[0] + rsp_cnt[1];
        @(posedge clk_clk);
        @(posedge clk_clk);
        #3;
        req[0] = 1'b0;
        model_last = 1'b1;
        last_result = '0;
        reset_reset_n = 1'b1;
        repeat (10) @(posedge clk_clk);
        #1;
        chk("no_rsp_after_reset", rsp_cnt[0] + rsp_cnt[1] - rs, 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
